mk8_pio_pulse_master: RTL and testbench



---
 rtl/mk8_pio_pulse_master.sv | 187 ++++++++++++++++++
 tb/tb_mk8_pio_pulse_master.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mk8_pio_pulse_master.sv
// mk8_pio_pulse_master
// Avalon-MM master that pulses PIO output lanes: it writes PULSE_MASK to the
// slave's bit-set alias, waits HOLD_CYCLES clocks, then writes PULSE_MASK to
// the bit-clear alias and pulses done.
// Optional feature: define MK8_PIO_PULSE_READBACK_EN to read the PIO back
// after each write and flag a lane mismatch on the sticky err output.
module mk8_pio_pulse_master #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter logic [31:0] PULSE_MASK  = 32'h0000_0001,
    parameter logic [2:0]  SET_ADDR    = 3'd4,
    parameter logic [2:0]  CLR_ADDR    = 3'd5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic        avm_read,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET_WR,
        S_SET_RD,
        S_HOLD,
        S_CLR_WR,
        S_CLR_RD,
        S_DONE
    } state_t;

    typedef struct packed {
        logic        chipselect;
        logic        write_n;
        logic        read;
        logic [2:0]  address;
        logic [31:0] writedata;
    } bus_t;

    localparam bus_t BUS_IDLE = '{chipselect: 1'b0, write_n: 1'b1, read: 1'b0,
                                  address: 3'd0, writedata: 32'd0};

    // A hold of zero clocks is treated as one clock.
    localparam logic [15:0] HOLD_LOAD = (HOLD_CYCLES == 0) ? 16'd1 : HOLD_CYCLES[15:0];

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    bus_t        bus_q, bus_d;

`ifndef MK8_PIO_PULSE_READBACK_EN
    // Read data is only consumed by the readback build.
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata;
`endif

    // Next-state, hold counter and sticky error; a stalled transfer keeps its state.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SET_WR;
                    err_d   = 1'b0;
                end
            end
            S_SET_WR: begin
                if (!avm_waitrequest) begin
`ifdef MK8_PIO_PULSE_READBACK_EN
                    state_d = S_SET_RD;
`else
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LOAD;
`endif
                end
            end
`ifdef MK8_PIO_PULSE_READBACK_EN
            S_SET_RD: begin
                if (!avm_waitrequest) begin
                    if ((avm_readdata & PULSE_MASK) != PULSE_MASK) err_d = 1'b1;
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
`endif
            S_HOLD: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q <= 16'd1) begin
                    state_d = S_CLR_WR;
                    cnt_d   = 16'd0;
                end
            end
            S_CLR_WR: begin
                if (!avm_waitrequest) begin
`ifdef MK8_PIO_PULSE_READBACK_EN
                    state_d = S_CLR_RD;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef MK8_PIO_PULSE_READBACK_EN
            S_CLR_RD: begin
                if (!avm_waitrequest) begin
                    if ((avm_readdata & PULSE_MASK) != 32'd0) err_d = 1'b1;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    always_comb begin
        bus_d  = BUS_IDLE;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        case (state_d)
            S_SET_WR: begin
                bus_d.chipselect = 1'b1;
                bus_d.write_n    = 1'b0;
                bus_d.address    = SET_ADDR;
                bus_d.writedata  = PULSE_MASK;
            end
            S_CLR_WR: begin
                bus_d.chipselect = 1'b1;
                bus_d.write_n    = 1'b0;
                bus_d.address    = CLR_ADDR;
                bus_d.writedata  = PULSE_MASK;
            end
`ifdef MK8_PIO_PULSE_READBACK_EN
            S_SET_RD, S_CLR_RD: begin
                bus_d.chipselect = 1'b1;
                bus_d.read       = 1'b1;
            end
`endif
            default: bus_d = BUS_IDLE;
        endcase
    end

    // State and output registers; reset forces the bus idle immediately.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: reset is asynchronous, so every flop here is cleared the moment
        // reset rises, even in the middle of a stalled transfer.
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bus_q   <= BUS_IDLE;
        end else begin
            // NOTE: non-blocking assignments so all flops update together from
            // the values computed before this edge.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bus_q   <= bus_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign avm_chipselect = bus_q.chipselect;
    assign avm_write_n    = bus_q.write_n;
    assign avm_read       = bus_q.read;
    assign avm_address    = bus_q.address;
    assign avm_writedata  = bus_q.writedata;

endmodule

// File: tb/tb_mk8_pio_pulse_master.sv
// Directed bench for mk8_pio_pulse_master: an H=16 instance with a PIO slave
// model, plus an H=0 instance checked against H=1 timing.
module tb_mk8_pio_pulse_master;

`ifdef MK8_PIO_PULSE_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam logic [31:0] MASK = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, waitreq;
    logic        busy, done, err;
    logic [2:0]  addr;
    logic        cs, write_n, rd;
    logic [31:0] wdata, rdata;

    logic        start0;
    logic        busy0, done0, err0;
    logic [2:0]  addr0;
    logic        cs0, write_n0, rd0;
    logic [31:0] wdata0;

    logic [31:0] pio;
    logic        bad_slave;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mk8_pio_pulse_master #(.HOLD_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
        .avm_address(addr), .avm_chipselect(cs), .avm_write_n(write_n), .avm_read(rd),
        .avm_writedata(wdata), .avm_readdata(rdata), .avm_waitrequest(waitreq)
    );

    mk8_pio_pulse_master #(.HOLD_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0), .err(err0),
        .avm_address(addr0), .avm_chipselect(cs0), .avm_write_n(write_n0), .avm_read(rd0),
        .avm_writedata(wdata0), .avm_readdata(32'd0), .avm_waitrequest(1'b0)
    );

    // PIO slave model with set/clear aliases; not touched by the master's reset.
    initial pio = 32'd0;
    always @(posedge clk) begin
        if (cs && !write_n && !waitreq) begin
            if (addr == 3'd4) pio <= pio | wdata;
            if (addr == 3'd5) pio <= pio & ~wdata;
        end
    end
    assign rdata = bad_slave ? 32'd0 : pio;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start one sequence (start high in the current cycle = cycle 0) and record events.
    task automatic observe(input int wait_from, input int wait_to,
                           input int start_a, input int start_b,
                           output int set_first, output int set_cycles,
                           output int clr_first, output int clr_cycles,
                           output int done_cyc, output int busy_cycles,
                           output int bit_cycles, output int bad_data,
                           output logic err_c1, output logic err_done);
        set_first = -1; set_cycles = 0; clr_first = -1; clr_cycles = 0;
        done_cyc = -1; busy_cycles = 0; bit_cycles = 0; bad_data = 0;
        err_c1 = 1'bx; err_done = 1'bx;
        start   = 1'b1;
        waitreq = 1'b0;
        for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
            tick();
            start   = (c == start_a) || (c == start_b);
            waitreq = (c >= wait_from) && (c <= wait_to);
            if (cs && !write_n) begin
                if (wdata !== MASK) bad_data++;
                if (addr == 3'd4) begin
                    if (set_first < 0) set_first = c;
                    set_cycles++;
                end else if (addr == 3'd5) begin
                    if (clr_first < 0) clr_first = c;
                    clr_cycles++;
                end else begin
                    bad_data++;
                end
            end
            if (busy) busy_cycles++;
            if (pio[0]) bit_cycles++;
            if (c == 1) err_c1 = err;
            if (done) begin
                done_cyc = c;
                err_done = err;
            end
        end
        waitreq = 1'b0;
    endtask

    initial begin
        int   sf, sc, cf, cc, dc, bc, bt, bd;
        logic e1, ed;
        int   cs_seen, clr0, done0_c, set0;

        reset = 1'b1; start = 1'b0; start0 = 1'b0; waitreq = 1'b0; bad_slave = 1'b0;
        #22;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_cs", {31'd0, cs}, 32'd0);
        check("rst_write_n", {31'd0, write_n}, 32'd1);
        check("rst_read", {31'd0, rd}, 32'd0);
        check("rst_addr", {29'd0, addr}, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        reset = 1'b0;
        tick();

        // Plain sequence, no stalls.
        observe(0, -1, -1, -1, sf, sc, cf, cc, dc, bc, bt, bd, e1, ed);
        check("nom_set_cycle", sf, 1);
        check("nom_set_len", sc, 1);
        check("nom_clr_cycle", cf, 18 + RB);
        check("nom_clr_len", cc, 1);
        check("nom_done_cycle", dc, 19 + 2 * RB);
        check("nom_busy_len", bc, 19 + 2 * RB);
        check("nom_bit_high", bt, 17 + RB);
        check("nom_bad_data", bd, 0);
        check("nom_err", {31'd0, ed}, 32'd0);
        tick();
        check("nom_busy_after", {31'd0, busy}, 32'd0);
        check("nom_done_after", {31'd0, done}, 32'd0);

        // Three wait-state cycles on the set write.
        observe(1, 3, -1, -1, sf, sc, cf, cc, dc, bc, bt, bd, e1, ed);
        check("stall_set_cycle", sf, 1);
        check("stall_set_len", sc, 4);
        check("stall_bad_data", bd, 0);
        check("stall_clr_cycle", cf, 21 + RB);
        check("stall_done_cycle", dc, 22 + 2 * RB);
        check("stall_bit_high", bt, 17 + RB);
        tick();

        // start during HOLD and in the DONE cycle is ignored.
        observe(0, -1, 5, 19 + 2 * RB, sf, sc, cf, cc, dc, bc, bt, bd, e1, ed);
        check("b2b_set_len", sc, 1);
        check("b2b_clr_len", cc, 1);
        check("b2b_done_cycle", dc, 19 + 2 * RB);
        tick();
        check("b2b_idle_busy", {31'd0, busy}, 32'd0);
        check("b2b_idle_cs", {31'd0, cs}, 32'd0);
        // start still high in this IDLE cycle: accepted.
        observe(0, -1, -1, -1, sf, sc, cf, cc, dc, bc, bt, bd, e1, ed);
        check("b2b_second_set", sf, 1);
        check("b2b_second_done", dc, 19 + 2 * RB);
        tick();

        // Reset in the middle of HOLD.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_cs", {31'd0, cs}, 32'd0);
        check("midrst_write_n", {31'd0, write_n}, 32'd1);
        check("midrst_done", {31'd0, done}, 32'd0);
        #2 reset = 1'b0;
        cs_seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (cs) cs_seen++;
        end
        check("midrst_no_clear", cs_seen, 0);
        observe(0, -1, -1, -1, sf, sc, cf, cc, dc, bc, bt, bd, e1, ed);
        check("midrst_restart_set", sf, 1);
        check("midrst_restart_done", dc, 19 + 2 * RB);
        tick();

`ifdef MK8_PIO_PULSE_READBACK_EN
        // Slave reads back zero: err sets, the sequence still completes.
        bad_slave = 1'b1;
        observe(0, -1, -1, -1, sf, sc, cf, cc, dc, bc, bt, bd, e1, ed);
        check("rb_err_set", {31'd0, ed}, 32'd1);
        check("rb_clr_issued", cc, 1);
        check("rb_done_cycle", dc, 21);
        bad_slave = 1'b0;
        tick();
        check("rb_err_sticky", {31'd0, err}, 32'd1);
        observe(0, -1, -1, -1, sf, sc, cf, cc, dc, bc, bt, bd, e1, ed);
        check("rb_err_cleared", {31'd0, e1}, 32'd0);
        check("rb_err_clean_end", {31'd0, ed}, 32'd0);
        tick();
`endif

        // HOLD_CYCLES=0 instance must time like HOLD_CYCLES=1.
        set0 = -1; clr0 = -1; done0_c = -1;
        start0 = 1'b1;
        for (int c = 1; c <= 40 && done0_c < 0; c++) begin
            tick();
            start0 = 1'b0;
            if (cs0 && !write_n0 && addr0 == 3'd4 && set0 < 0) set0 = c;
            if (cs0 && !write_n0 && addr0 == 3'd5 && clr0 < 0) clr0 = c;
            if (done0) done0_c = c;
        end
        check("h0_set_cycle", set0, 1);
        check("h0_clr_cycle", clr0, 3 + RB);
        check("h0_done_cycle", done0_c, 4 + 2 * RB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
